// File: rtl/seq_detect_gen_if.sv
// Control and status bundle for seq_detect_gen: board-side controls in, LED/debug status out.
interface seq_detect_gen_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             load;
    logic             ext_mode;
    logic             ext_in;
    logic             tick;
    logic             in_bit;
    logic             match;
    logic             match_pulse;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    modport master (
        output en, load, ext_mode, ext_in,
        input  tick, in_bit, match, match_pulse, match_cnt, done
    );

    modport slave (
        input  en, load, ext_mode, ext_in,
        output tick, in_bit, match, match_pulse, match_cnt, done
    );
endinterface

// File: rtl/seq_detect_gen.sv
// Moore sequence detector fed one bit per divided tick from a built-in pattern or an external pin.
// Detector state is the matched prefix length k (S0..S[SEQ_LEN]); the pass FSM below tracks single-pass completion.
//   state     | meaning
//   PASS_RUN  | ticks consume bits and advance the detector
//   PASS_DONE | LOOP=0 only: last pattern bit consumed, ticks ignored until load/reset
module seq_detect_gen #(
    parameter int                   PAT_LEN  = 20,
    parameter logic [PAT_LEN-1:0]   PATTERN  = 20'b11001000010110110111,
    parameter int                   SEQ_LEN  = 4,
    parameter logic [SEQ_LEN-1:0]   SEQUENCE = 4'b0011,
    parameter bit                   OVERLAP  = 1'b1,
    parameter bit                   LOOP     = 1'b1,
    parameter int                   DIV      = 50000,
    parameter int                   CNT_W    = 8
) (
    input logic             clk,
    input logic             reset,
    seq_detect_gen_if.slave bus
);

    localparam int SW = $clog2(SEQ_LEN + 1);
    localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(PAT_LEN - 1);
    localparam logic [SW-1:0]    S_FULL   = SW'(SEQ_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {
        PASS_RUN  = 1'b0,
        PASS_DONE = 1'b1
    } pass_t;

    logic [DW-1:0]    div_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    state_q;
    pass_t            pass_q;
    logic             in_bit_q;
    logic             match_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    logic             tick;
    logic             src;
    logic [SW-1:0]    state_nx;

    // Longest SEQUENCE prefix that is a suffix of (current prefix + new bit); KMP fallback without a table.
    function automatic logic [SW-1:0] next_state(input logic [SW-1:0] cur, input logic b);
        int   k;
        int   best;
        int   pos;
        logic hit;
        logic rb;
        k = int'(cur);
        if (!OVERLAP && k == SEQ_LEN) k = 0;
        best = 0;
        for (int j = 1; j <= SEQ_LEN; j++) begin
            hit = (j <= k + 1);
            for (int m = 0; m < SEQ_LEN; m++) begin
                if (hit && m < j) begin
                    pos = k + 1 - j + m;
                    rb  = b;
                    if (pos >= 0 && pos < k) rb = SEQUENCE[SEQ_LEN-1-pos];
                    if (rb != SEQUENCE[SEQ_LEN-1-m]) hit = 1'b0;
                end
            end
            if (hit) best = j;
        end
        return SW'(best);
    endfunction

    assign tick     = bus.en && !bus.load && (div_q == DIV_LAST);
    assign src      = bus.ext_mode ? bus.ext_in : PATTERN[idx_q];
    assign state_nx = next_state(state_q, src);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            idx_q    <= '0;
            state_q  <= '0;
            pass_q   <= PASS_RUN;
            in_bit_q <= 1'b0;
            match_q  <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.load) begin
                div_q   <= '0;
                idx_q   <= '0;
                state_q <= '0;
                pass_q  <= PASS_RUN;
                match_q <= 1'b0;
                cnt_q   <= '0;
            end else if (bus.en) begin
                if (div_q == DIV_LAST) div_q <= '0;
                else                   div_q <= div_q + 1'b1;
                if (div_q == DIV_LAST && pass_q == PASS_RUN) begin
                    in_bit_q <= src;
                    state_q  <= state_nx;
                    match_q  <= (state_nx == S_FULL);
                    if (state_nx == S_FULL) begin
                        pulse_q <= 1'b1;
                        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                    end
                    // The external pin does not consume pattern positions.
                    if (!bus.ext_mode) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
                            if (!LOOP) pass_q <= PASS_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.tick        = tick;
    assign bus.in_bit      = in_bit_q;
    assign bus.match       = match_q;
    assign bus.match_pulse = pulse_q;
    assign bus.match_cnt   = cnt_q;
    assign bus.done        = (pass_q == PASS_DONE);

endmodule

// File: tb/tb_seq_detect_gen.sv
// Bench for seq_detect_gen: scoreboarded random run on a default-pattern instance plus
// directed checks on small-parameter instances (non-overlap/single pass, saturation, overlap).
module tb_seq_detect_gen;

    localparam int DIV_A = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [19:0] pat_bits = 20'b11001000010110110111;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_gen_if #(.CNT_W(8)) bus_a ();
    seq_detect_gen_if #(.CNT_W(2)) bus_b ();
    seq_detect_gen_if #(.CNT_W(2)) bus_c ();
    seq_detect_gen_if #(.CNT_W(8)) bus_d ();

    seq_detect_gen #(.DIV(DIV_A)) u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

    seq_detect_gen #(.SEQ_LEN(3), .SEQUENCE(3'b101), .OVERLAP(1'b0), .LOOP(1'b0), .DIV(1), .CNT_W(2))
        u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    seq_detect_gen #(.SEQ_LEN(1), .SEQUENCE(1'b1), .OVERLAP(1'b1), .DIV(1), .CNT_W(2))
        u_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

    seq_detect_gen #(.SEQ_LEN(3), .SEQUENCE(3'b101), .OVERLAP(1'b1), .DIV(1))
        u_d (.clk(clk), .reset(reset), .bus(bus_d.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per tick or load cycle predicted by the reference model.
    typedef struct {
        int cyc;
        bit is_tick;
        bit in_bit;
        bit match;
        bit pulse;
        int cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model: spec-level view (enabled-cycle count, last four bits, saturating count).
    int     m_div, m_idx, m_cnt, m_nbits;
    bit [3:0] m_last;
    bit     m_in_bit;

    task automatic model_clear(input bit full);
        m_div = 0; m_idx = 0; m_cnt = 0; m_nbits = 0; m_last = '0;
        if (full) m_in_bit = 1'b0;
    endtask

    task automatic a_cycle(input bit en, input bit ld, input bit xm, input bit xi);
        bit s;
        bit hit;
        exp_t e;
        bus_a.en = en; bus_a.load = ld; bus_a.ext_mode = xm; bus_a.ext_in = xi;
        if (ld) begin
            model_clear(1'b0);
            e = '{cyc: cyc, is_tick: 1'b0, in_bit: m_in_bit, match: 1'b0, pulse: 1'b0, cnt: 0};
            sb.push_back(e);
        end else if (en) begin
            if (m_div == DIV_A - 1) begin
                m_div = 0;
                s = xm ? xi : pat_bits[m_idx];
                if (!xm) m_idx = (m_idx + 1) % 20;
                m_last = {m_last[2:0], s};
                if (m_nbits < 4) m_nbits++;
                hit = (m_nbits == 4) && (m_last == 4'b0011);
                if (hit && m_cnt < 255) m_cnt++;
                m_in_bit = s;
                e = '{cyc: cyc, is_tick: 1'b1, in_bit: s, match: hit, pulse: hit, cnt: m_cnt};
                sb.push_back(e);
            end else begin
                m_div++;
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every observed tick/load, checks outputs after the following edge.
    initial begin : monitor
        exp_t cur;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("a_in_bit", bus_a.in_bit, cur.in_bit);
                check("a_match", bus_a.match, cur.match);
                check("a_pulse", bus_a.match_pulse, cur.pulse);
                check("a_cnt", bus_a.match_cnt, cur.cnt);
                check("a_done", bus_a.done, 1'b0);
                pend = 1'b0;
            end else if (reset === 1'b1) begin
                check("a_pulse_idle", bus_a.match_pulse, 1'b0);
            end
            if (bus_a.tick === 1'b1 || bus_a.load === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL a_unexpected_event: tick=%0b load=%0b at cycle %0d, none expected",
                             bus_a.tick, bus_a.load, cyc);
                end else begin
                    cur = sb.pop_front();
                    check("a_event_cycle", cyc, cur.cyc);
                    check("a_event_kind", bus_a.tick, cur.is_tick);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic b_tick(input bit xm, input bit xi);
        bus_b.ext_mode = xm; bus_b.ext_in = xi; bus_b.en = 1'b1;
        @(posedge clk); #1;
        bus_b.en = 1'b0;
    endtask

    task automatic b_load();
        bus_b.load = 1'b1;
        @(posedge clk); #1;
        bus_b.load = 1'b0;
    endtask

    task automatic c_tick(input bit xi);
        bus_c.ext_mode = 1'b1; bus_c.ext_in = xi; bus_c.en = 1'b1;
        @(posedge clk); #1;
        bus_c.en = 1'b0;
    endtask

    task automatic d_tick(input bit xi);
        bus_d.ext_mode = 1'b1; bus_d.ext_in = xi; bus_d.en = 1'b1;
        @(posedge clk); #1;
        bus_d.en = 1'b0;
    endtask

    task automatic a_reset_check();
        reset = 1'b0;
        model_clear(1'b1);
        #1;
        check("a_reset_outputs",
              {bus_a.tick, bus_a.in_bit, bus_a.match, bus_a.match_pulse, bus_a.done, bus_a.match_cnt},
              '0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: bench did not finish within 2 ms");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit bext[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bit bmatch[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int bcnt[5]  = '{0, 0, 1, 1, 1};
        bit dmatch[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int dcnt[5]  = '{0, 0, 1, 1, 2};
        int ccnt[6]  = '{1, 2, 3, 3, 3, 3};

        {bus_a.en, bus_a.load, bus_a.ext_mode, bus_a.ext_in} = '0;
        {bus_b.en, bus_b.load, bus_b.ext_mode, bus_b.ext_in} = '0;
        {bus_c.en, bus_c.load, bus_c.ext_mode, bus_c.ext_in} = '0;
        {bus_d.en, bus_d.load, bus_d.ext_mode, bus_d.ext_in} = '0;
        model_clear(1'b1);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("a_reset_state",
              {bus_a.tick, bus_a.in_bit, bus_a.match, bus_a.match_pulse, bus_a.done, bus_a.match_cnt},
              '0);
        check("b_reset_done", bus_b.done, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        // Two full pattern passes: matches only at bit indices 19 and 39, no idle tick at wrap.
        repeat (40 * DIV_A) a_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("a_cnt_after_40_ticks", bus_a.match_cnt, 8'd2);
        check("a_match_after_bit39", bus_a.match, 1'b1);

        a_reset_check();

        for (int half = 0; half < 2; half++) begin
            repeat (1500)
                a_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
                        $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (half == 0) a_reset_check();
        end
        repeat (3) a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("a_scoreboard_drained", sb.size(), 0);

        // Non-overlapping 101 on 1,0,1,0,1 -> one match.
        b_load();
        for (int i = 0; i < 5; i++) begin
            b_tick(1'b1, bext[i]);
            check("b_ext_match", bus_b.match, bmatch[i]);
            check("b_ext_cnt", bus_b.match_cnt, bcnt[i]);
        end

        // Single pass over the pattern: 101 at indices 4, 7, 10; done exactly after the 20th bit.
        b_load();
        check("b_load_cnt", bus_b.match_cnt, 2'd0);
        for (int i = 0; i < 20; i++) begin
            b_tick(1'b0, 1'b0);
            check("b_pat_match", bus_b.match, (i == 4 || i == 7 || i == 10));
            check("b_pat_done", bus_b.done, (i == 19));
        end
        check("b_pass_cnt", bus_b.match_cnt, 2'd3);
        check("b_pass_in_bit", bus_b.in_bit, 1'b1);
        for (int i = 0; i < 10; i++) begin
            b_tick(i[0], 1'b0);
            check("b_frozen_in_bit", bus_b.in_bit, 1'b1);
            check("b_frozen_cnt", bus_b.match_cnt, 2'd3);
            check("b_frozen_done", bus_b.done, 1'b1);
        end
        b_load();
        check("b_reload_done", bus_b.done, 1'b0);
        check("b_reload_cnt", bus_b.match_cnt, 2'd0);
        check("b_reload_in_bit", bus_b.in_bit, 1'b1);

        // Single-bit target, six ones: saturating count and a pulse on every re-entry.
        for (int i = 0; i < 6; i++) begin
            c_tick(1'b1);
            check("c_pulse", bus_c.match_pulse, 1'b1);
            check("c_cnt", bus_c.match_cnt, ccnt[i]);
        end
        @(posedge clk); #1;
        check("c_pulse_fall", bus_c.match_pulse, 1'b0);
        check("c_match_hold", bus_c.match, 1'b1);

        // Overlapping 101 on 1,0,1,0,1 -> two matches.
        for (int i = 0; i < 5; i++) begin
            d_tick(bext[i]);
            check("d_match", bus_d.match, dmatch[i]);
            check("d_pulse", bus_d.match_pulse, dmatch[i]);
            check("d_cnt", bus_d.match_cnt, dcnt[i]);
        end

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
